snoop_cache: RTL and testbench

//   Single-line, single-word write-back MSI cache between one processor and the shared memory bus.

---
 rtl/snoop_cache.sv | 206 ++++++++++++++++++++
 tb/tb_snoop_cache.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/snoop_cache.sv
// Single-line, single-word write-back MSI cache with a point-to-point snoop
// link to one peer cache and a request/ack port to the shared memory bus.
module snoop_cache #(
   parameter int WORD_W  = 16,
   parameter int ADDR_W  = 8,
   parameter int IO_W    = 2,
   parameter int STATE_W = 2,
   parameter bit MASTER  = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [IO_W-1:0]   rwFromCPU,
   input  logic [ADDR_W-1:0] addrFromCPU,
   input  logic [WORD_W-1:0] dataFromCPU,
   output logic              cacheEnToCPU,
   output logic [WORD_W-1:0] dataToCPU,
   input  logic [WORD_W-1:0] dataFromMem,
   input  logic              memEn,
   output logic [IO_W-1:0]   rwToMem,
   output logic [ADDR_W-1:0] addrToMem,
   output logic [WORD_W-1:0] dataToMem,
   input  logic              havMsgFromCache,
   input  logic              rmFromCache,
   input  logic              wmFromCache,
   input  logic              invFromCache,
   input  logic [ADDR_W-1:0] addrFromCache,
   input  logic              allowReadFromCache,
   input  logic [ADDR_W-1:0] allowReadFromCacheAddr,
   output logic              havMsgToCache,
   output logic              rmToCache,
   output logic              wmToCache,
   output logic              invToCache,
   output logic [ADDR_W-1:0] addrToCache,
   output logic              allowReadToCache,
   output logic [ADDR_W-1:0] allowReadToCacheAddr,
   output logic [STATE_W-1:0] debugState,
   output logic [WORD_W-1:0] debugCacheLine
);

   localparam logic [STATE_W-1:0] ST_I = STATE_W'(0);
   localparam logic [STATE_W-1:0] ST_S = STATE_W'(1);
   localparam logic [STATE_W-1:0] ST_M = STATE_W'(2);
   localparam logic [IO_W-1:0]    RW_RD = IO_W'(1);
   localparam logic [IO_W-1:0]    RW_WR = IO_W'(2);

   typedef enum logic [2:0] {
      IDLE, WB, REQ, MEMRD, DONE, SWB, SACK
   } fsm_t;

   fsm_t              fsm, fsm_nx, snp_fsm;
   logic [STATE_W-1:0] coh, coh_nx, snp_coh;
   logic [ADDR_W-1:0] tag, tag_nx;
   logic [WORD_W-1:0] line, line_nx;
   logic [2:0]        kind, kind_nx;
   logic [ADDR_W-1:0] snp_addr, snp_addr_nx;
   logic              snp_rm, snp_rm_nx;

   logic cpu_rd, cpu_wr, cpu_go, hit, snp_hit, acked;

   assign cpu_rd  = (rwFromCPU == RW_RD);
   assign cpu_wr  = (rwFromCPU == RW_WR);
   assign cpu_go  = (cpu_rd || cpu_wr) && !allowReadFromCache;
   assign hit     = (tag == addrFromCPU) && (coh != ST_I);
   assign snp_hit = (tag == addrFromCache) && (coh != ST_I);
   assign acked   = allowReadFromCache &&
                    (allowReadFromCacheAddr == addrFromCPU);

   assign debugState     = coh;
   assign debugCacheLine = line;

   // Snoop outcome: dirty copies are flushed before acking
   always_comb begin
      snp_fsm = SACK;
      snp_coh = coh;
      if (snp_hit && coh == ST_M && (rmFromCache || wmFromCache))
         snp_fsm = SWB;
      else if (snp_hit && coh == ST_S && (wmFromCache || invFromCache))
         snp_coh = ST_I;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fsm      <= IDLE;
         coh      <= ST_I;
         tag      <= '0;
         line     <= '0;
         kind     <= '0;
         snp_addr <= '0;
         snp_rm   <= 1'b0;
      end else begin
         fsm      <= fsm_nx;
         coh      <= coh_nx;
         tag      <= tag_nx;
         line     <= line_nx;
         kind     <= kind_nx;
         snp_addr <= snp_addr_nx;
         snp_rm   <= snp_rm_nx;
      end
   end

   always_comb begin
      fsm_nx      = fsm;
      coh_nx      = coh;
      tag_nx      = tag;
      line_nx     = line;
      kind_nx     = kind;
      snp_addr_nx = snp_addr;
      snp_rm_nx   = snp_rm;
      cacheEnToCPU         = 1'b0;
      dataToCPU            = '0;
      rwToMem              = '0;
      addrToMem            = '0;
      dataToMem            = '0;
      havMsgToCache        = 1'b0;
      rmToCache            = 1'b0;
      wmToCache            = 1'b0;
      invToCache           = 1'b0;
      addrToCache          = '0;
      allowReadToCache     = 1'b0;
      allowReadToCacheAddr = '0;
      unique case (fsm)
         IDLE: begin
            if (havMsgFromCache) begin
               fsm_nx      = snp_fsm;
               coh_nx      = snp_coh;
               snp_addr_nx = addrFromCache;
               snp_rm_nx   = rmFromCache;
            end else if (cpu_go) begin
               if (hit && cpu_rd) begin
                  fsm_nx = DONE;
               end else if (hit && coh == ST_M) begin
                  line_nx = dataFromCPU;
                  fsm_nx  = DONE;
               end else begin
                  kind_nx = {cpu_rd, cpu_wr && !hit, cpu_wr && hit};
                  fsm_nx  = (!hit && coh == ST_M) ? WB : REQ;
               end
            end
         end
         WB: begin
            rwToMem   = RW_WR;
            addrToMem = tag;
            dataToMem = line;
            if (memEn) begin
               coh_nx = ST_I;
               fsm_nx = REQ;
            end
         end
         REQ: begin
            havMsgToCache = 1'b1;
            rmToCache     = kind[2];
            wmToCache     = kind[1];
            invToCache    = kind[0];
            addrToCache   = addrFromCPU;
            if (acked) begin
               if (kind[2]) begin
                  fsm_nx = MEMRD;
               end else begin
                  line_nx = dataFromCPU;
                  tag_nx  = addrFromCPU;
                  coh_nx  = ST_M;
                  fsm_nx  = DONE;
               end
            end else if (havMsgFromCache && !MASTER) begin
               // Yield to the master; own request is re-evaluated from IDLE
               fsm_nx      = snp_fsm;
               coh_nx      = snp_coh;
               snp_addr_nx = addrFromCache;
               snp_rm_nx   = rmFromCache;
            end
         end
         MEMRD: begin
            rwToMem   = RW_RD;
            addrToMem = addrFromCPU;
            if (memEn) begin
               line_nx = dataFromMem;
               tag_nx  = addrFromCPU;
               coh_nx  = ST_S;
               fsm_nx  = DONE;
            end
         end
         DONE: begin
            cacheEnToCPU = 1'b1;
            dataToCPU    = line;
            fsm_nx       = IDLE;
         end
         SWB: begin
            rwToMem   = RW_WR;
            addrToMem = tag;
            dataToMem = line;
            if (memEn) begin
               coh_nx = snp_rm ? ST_S : ST_I;
               fsm_nx = SACK;
            end
         end
         SACK: begin
            allowReadToCache     = 1'b1;
            allowReadToCacheAddr = snp_addr;
            if (!havMsgFromCache)
               fsm_nx = IDLE;
         end
         default: fsm_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_snoop_cache.sv
// Two cross-coupled snoop_cache instances on a shared behavioural memory
// bus; directed coherence vectors plus random ops against an MSI model.
module tb_snoop_cache;

   localparam logic [1:0] RD = 2'b01;
   localparam logic [1:0] WR = 2'b10;
   localparam logic [1:0] SI = 2'd0;
   localparam logic [1:0] SS = 2'd1;
   localparam logic [1:0] SM = 2'd2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic [1:0]  rw[2], rw_mem[2], st[2];
   logic [7:0]  ca[2], addr_mem[2], hav_addr[2], ack_addr[2];
   logic [15:0] cd[2], dout[2], din_mem[2], dout_mem[2], line[2];
   logic        en[2], mem_en[2], hav[2], rm[2], wm[2], inv[2], ack[2];
   logic [15:0] mem[256];

   snoop_cache #(.MASTER(1'b1)) c1 (
      .clk(clk), .reset(reset),
      .rwFromCPU(rw[0]), .addrFromCPU(ca[0]), .dataFromCPU(cd[0]),
      .cacheEnToCPU(en[0]), .dataToCPU(dout[0]),
      .dataFromMem(din_mem[0]), .memEn(mem_en[0]),
      .rwToMem(rw_mem[0]), .addrToMem(addr_mem[0]), .dataToMem(dout_mem[0]),
      .havMsgFromCache(hav[1]), .rmFromCache(rm[1]), .wmFromCache(wm[1]),
      .invFromCache(inv[1]), .addrFromCache(hav_addr[1]),
      .allowReadFromCache(ack[1]), .allowReadFromCacheAddr(ack_addr[1]),
      .havMsgToCache(hav[0]), .rmToCache(rm[0]), .wmToCache(wm[0]),
      .invToCache(inv[0]), .addrToCache(hav_addr[0]),
      .allowReadToCache(ack[0]), .allowReadToCacheAddr(ack_addr[0]),
      .debugState(st[0]), .debugCacheLine(line[0])
   );

   snoop_cache #(.MASTER(1'b0)) c2 (
      .clk(clk), .reset(reset),
      .rwFromCPU(rw[1]), .addrFromCPU(ca[1]), .dataFromCPU(cd[1]),
      .cacheEnToCPU(en[1]), .dataToCPU(dout[1]),
      .dataFromMem(din_mem[1]), .memEn(mem_en[1]),
      .rwToMem(rw_mem[1]), .addrToMem(addr_mem[1]), .dataToMem(dout_mem[1]),
      .havMsgFromCache(hav[0]), .rmFromCache(rm[0]), .wmFromCache(wm[0]),
      .invFromCache(inv[0]), .addrFromCache(hav_addr[0]),
      .allowReadFromCache(ack[0]), .allowReadFromCacheAddr(ack_addr[0]),
      .havMsgToCache(hav[1]), .rmToCache(rm[1]), .wmToCache(wm[1]),
      .invToCache(inv[1]), .addrToCache(hav_addr[1]),
      .allowReadToCache(ack[1]), .allowReadToCacheAddr(ack_addr[1]),
      .debugState(st[1]), .debugCacheLine(line[1])
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [95:0] act,
                      input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [95:0] outs(input int c);
      return 96'({en[c], dout[c], rw_mem[c], addr_mem[c], dout_mem[c],
                  hav[c], rm[c], wm[c], inv[c], hav_addr[c], ack[c],
                  ack_addr[c], st[c], line[c]});
   endfunction

   // Memory bus: one access at a time, random 1..3 cycle latency
   initial begin
      int cur;
      int cnt;
      int pri;
      int cc;
      cur = -1; cnt = 0; pri = 0;
      for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
      mem_en[0] = 1'b0; mem_en[1] = 1'b0;
      din_mem[0] = '0; din_mem[1] = '0;
      forever begin
         @(posedge clk); #1;
         mem_en[0] = 1'b0; mem_en[1] = 1'b0;
         if (reset) begin
            cur = -1;
         end else if (cur >= 0) begin
            cnt--;
            if (cnt == 0) begin
               if (rw_mem[cur] == WR) mem[addr_mem[cur]] = dout_mem[cur];
               else din_mem[cur] = mem[addr_mem[cur]];
               mem_en[cur] = 1'b1;
               cur = -1;
            end
         end else begin
            for (int k = 0; k < 2; k++) begin
               cc = (pri + k) % 2;
               if (cur < 0 && rw_mem[cc] != 2'b00) begin
                  cur = cc;
                  cnt = int'($urandom_range(1, 3));
                  pri = 1 - cc;
               end
            end
         end
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      rw[0] = 2'b00; rw[1] = 2'b00;
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
   endtask

   task automatic cpu_op(input int c, input logic [1:0] op,
                         input logic [7:0] a, input logic [15:0] d,
                         output logic [15:0] q, output int n);
      rw[c] = op; ca[c] = a; cd[c] = d;
      q = '0; n = -1;
      for (int i = 1; i <= 300; i++) begin
         @(posedge clk); #1;
         if (en[c]) begin
            q = dout[c];
            n = i;
            break;
         end
      end
      rw[c] = 2'b00;
      chk($sformatf("cpu%0d done within bound", c), 96'(n > 0), 96'(1));
   endtask

   // Reference MSI model: two caches and a flat memory
   logic [1:0]  rs[2];
   logic [7:0]  rt[2];
   logic [15:0] rl[2];
   logic [15:0] rmem[256];

   task automatic model(input int c, input logic [1:0] op,
                        input logic [7:0] a, input logic [15:0] d,
                        output logic [15:0] q);
      int p;
      bit h, ph;
      p  = 1 - c;
      h  = (rt[c] == a) && (rs[c] != SI);
      ph = (rt[p] == a) && (rs[p] != SI);
      if (!(h && (op == RD || rs[c] == SM))) begin
         if (!h && rs[c] == SM) rmem[rt[c]] = rl[c];
         if (ph) begin
            if (rs[p] == SM) rmem[a] = rl[p];
            rs[p] = (op == RD) ? SS : SI;
         end
      end
      if (op == WR) begin
         rl[c] = d; rs[c] = SM; rt[c] = a;
      end else if (!h) begin
         rl[c] = rmem[a]; rs[c] = SS; rt[c] = a;
      end
      q = rl[c];
   endtask

   typedef struct {
      bit          rst;
      int          c;
      logic [1:0]  op;
      logic [7:0]  a;
      logic [15:0] d;
      logic [15:0] q;
      logic [1:0]  s0, s1;
      logic [15:0] l0, l1;
      logic [7:0]  ma;
      logic [15:0] mv;
   } vec_t;

   vec_t tbl[12];
   logic [15:0] q, q0, q1, rq;
   int n, n0, n1;
   logic [1:0] rop;
   logic [7:0] ra;
   logic [15:0] rd;
   int rc;
   bit seen;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 2; i++) begin
         rw[i] = 2'b00; ca[i] = '0; cd[i] = '0;
      end
      tbl[0]  = '{1'b1, 0, WR, 8'h00, 16'h0003, 16'h0, SM, SI, 16'h0003, 16'h0, 8'h00, 16'h1000};
      tbl[1]  = '{1'b0, 1, WR, 8'h00, 16'h0004, 16'h0, SI, SM, 16'h0, 16'h0004, 8'h00, 16'h0003};
      tbl[2]  = '{1'b1, 0, WR, 8'h00, 16'h0003, 16'h0, SM, SI, 16'h0003, 16'h0, 8'h00, 16'h0003};
      tbl[3]  = '{1'b0, 1, RD, 8'h00, 16'h0000, 16'h3, SS, SS, 16'h0003, 16'h0003, 8'h00, 16'h0003};
      tbl[4]  = '{1'b1, 0, WR, 8'h00, 16'h0003, 16'h0, SM, SI, 16'h0003, 16'h0, 8'h00, 16'h0003};
      tbl[5]  = '{1'b0, 0, RD, 8'h00, 16'h0000, 16'h3, SM, SI, 16'h0003, 16'h0, 8'h00, 16'h0003};
      tbl[6]  = '{1'b0, 1, RD, 8'h00, 16'h0000, 16'h3, SS, SS, 16'h0003, 16'h0003, 8'h00, 16'h0003};
      tbl[7]  = '{1'b0, 1, WR, 8'h00, 16'h0004, 16'h0, SI, SM, 16'h0, 16'h0004, 8'h00, 16'h0003};
      tbl[8]  = '{1'b0, 1, RD, 8'h05, 16'h0000, 16'h1005, SI, SS, 16'h0, 16'h1005, 8'h00, 16'h0004};
      tbl[9]  = '{1'b0, 0, WR, 8'h07, 16'hBEEF, 16'h0, SM, SS, 16'hBEEF, 16'h1005, 8'h07, 16'h1007};
      tbl[10] = '{1'b0, 0, WR, 8'h09, 16'h1234, 16'h0, SM, SS, 16'h1234, 16'h1005, 8'h07, 16'hBEEF};
      tbl[11] = '{1'b0, 1, RD, 8'h09, 16'h0000, 16'h1234, SS, SS, 16'h1234, 16'h1234, 8'h09, 16'h1234};

      do_reset();
      chk("reset outputs c1", outs(0), 96'(0));
      chk("reset outputs c2", outs(1), 96'(0));

      for (int i = 0; i < 12; i++) begin
         if (tbl[i].rst) do_reset();
         cpu_op(tbl[i].c, tbl[i].op, tbl[i].a, tbl[i].d, q, n);
         if (tbl[i].op == RD)
            chk($sformatf("vec%0d load data", i), 96'(q), 96'(tbl[i].q));
         chk($sformatf("vec%0d c1 state", i), 96'(st[0]), 96'(tbl[i].s0));
         chk($sformatf("vec%0d c2 state", i), 96'(st[1]), 96'(tbl[i].s1));
         if (tbl[i].s0 != SI)
            chk($sformatf("vec%0d c1 line", i), 96'(line[0]), 96'(tbl[i].l0));
         if (tbl[i].s1 != SI)
            chk($sformatf("vec%0d c2 line", i), 96'(line[1]), 96'(tbl[i].l1));
         chk($sformatf("vec%0d mem[%0h]", i, tbl[i].ma),
             96'(mem[tbl[i].ma]), 96'(tbl[i].mv));
      end

      do_reset();
      for (int c = 0; c < 2; c++) begin
         rs[c] = SI; rt[c] = '0; rl[c] = '0;
      end
      for (int i = 0; i < 256; i++) rmem[i] = mem[i];
      for (int i = 0; i < 80; i++) begin
         rc  = int'($urandom_range(0, 1));
         rop = ($urandom_range(0, 1) == 0) ? RD : WR;
         ra  = 8'($urandom_range(0, 3));
         rd  = 16'($urandom);
         model(rc, rop, ra, rd, rq);
         cpu_op(rc, rop, ra, rd, q, n);
         if (rop == RD)
            chk($sformatf("rnd%0d load data", i), 96'(q), 96'(rq));
         for (int c = 0; c < 2; c++) begin
            chk($sformatf("rnd%0d state%0d", i, c), 96'(st[c]), 96'(rs[c]));
            if (rs[c] != SI)
               chk($sformatf("rnd%0d line%0d", i, c), 96'(line[c]), 96'(rl[c]));
         end
      end
      for (int i = 0; i < 4; i++)
         chk($sformatf("rnd mem[%0d]", i), 96'(mem[i]), 96'(rmem[i]));

      do_reset();
      fork
         cpu_op(0, WR, 8'h00, 16'hAAAA, q0, n0);
         cpu_op(1, WR, 8'h00, 16'h5555, q1, n1);
      join
      chk("simul master first", 96'(n0 < n1), 96'(1));
      chk("simul c1 state", 96'(st[0]), 96'(SI));
      chk("simul c2 state", 96'(st[1]), 96'(SM));
      chk("simul c2 line", 96'(line[1]), 96'(16'h5555));
      chk("simul mem[0]", 96'(mem[0]), 96'(16'hAAAA));

      do_reset();
      rw[0] = RD; ca[0] = 8'h20; cd[0] = '0;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #2;
         if (rw_mem[0] == RD) begin
            seen = 1'b1;
            break;
         end
      end
      chk("mid-reset fetch pending", 96'(seen), 96'(1));
      reset = 1'b1;
      @(posedge clk); #2;
      chk("mid-reset outputs c1", outs(0), 96'(0));
      chk("mid-reset outputs c2", outs(1), 96'(0));
      rw[0] = 2'b00;
      @(posedge clk); #2;
      reset = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
